alu_cmd_driver: RTL and testbench

Sequential initiator for the team's 32-bit combinational ALU (ALU_32bit). Accepts operation commands over a valid/ready interface and registers the operands and opcode onto the ALU inputs. After a per-opcode settle time it captures ALU_Out/Carryout and returns the result over a valid/ready response interface. It guards divide-by-zero and, optionally, chains results through an accumulator.

---
 rtl/alu_drv_pkg.sv | 34 +++
 rtl/alu_cmd_driver.sv | 152 +++++++++++++++
 tb/tb_alu_cmd_driver.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_drv_pkg.sv
// Shared opcode encodings, FSM state type and settle-length helper for alu_cmd_driver.
package alu_drv_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_SHL  = 4'b0100;
    localparam logic [3:0] OP_SHR  = 4'b0101;
    localparam logic [3:0] OP_ROL  = 4'b0110;
    localparam logic [3:0] OP_ROR  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_XNOR = 4'b1101;
    localparam logic [3:0] OP_GT   = 4'b1110;
    localparam logic [3:0] OP_EQ   = 4'b1111;

    // One bit per opcode; set bits select the long settle time.
    localparam logic [15:0] LONG_SETTLE_MASK = 16'((1 << OP_MUL) | (1 << OP_DIV));

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESP
    } drv_state_t;

    function automatic logic is_long_settle(logic [3:0] sel);
        return LONG_SETTLE_MASK[sel];
    endfunction

endpackage

// File: rtl/alu_cmd_driver.sv
// Sequential command/response front end for the 32-bit combinational ALU.
// Optional result accumulator enabled by defining ALU_DRV_ACC_EN.
module alu_cmd_driver
    import alu_drv_pkg::*;
#(
    parameter int unsigned WIDTH              = 32,
    parameter int unsigned SETTLE_CYCLES      = 2,
    parameter int unsigned LONG_SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_sel,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_acc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_err
);

    drv_state_t       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]       alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_err_q, rsp_err_d;
    logic [WIDTH-1:0] eff_a;

`ifdef ALU_DRV_ACC_EN
    logic [WIDTH-1:0] acc_q, acc_d;

    assign eff_a = cmd_acc ? acc_q : cmd_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    logic unused_cmd_acc;

    assign unused_cmd_acc = cmd_acc;
    assign eff_a          = cmd_a;
`endif

    // Gated with rst_n so the port reads 0 for the whole reset assertion.
    assign cmd_ready = rst_n && (state_q == IDLE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_err_d   = rsp_err_q;
`ifdef ALU_DRV_ACC_EN
        acc_d       = acc_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    alu_a_d   = eff_a;
                    alu_b_d   = cmd_b;
                    alu_sel_d = cmd_sel;
                    if (cmd_sel == OP_DIV && cmd_b == '0) begin
                        // Divide-by-zero short-circuits the settle and never samples the ALU.
                        rsp_data_d  = '1;
                        rsp_carry_d = 1'b0;
                        rsp_zero_d  = 1'b0;
                        rsp_err_d   = 1'b1;
                        state_d     = RESP;
                    end else begin
                        cnt_d   = is_long_settle(cmd_sel) ? 4'(LONG_SETTLE_CYCLES - 1)
                                                          : 4'(SETTLE_CYCLES - 1);
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    rsp_data_d  = alu_out;
                    rsp_carry_d = alu_carry;
                    rsp_zero_d  = (alu_out == '0);
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
`ifdef ALU_DRV_ACC_EN
                    acc_d       = alu_out;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= 4'b0000;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b1;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed self-checking bench for alu_cmd_driver with a behavioural 32-bit ALU beside it.
module tb_alu_cmd_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_acc;
    logic [3:0]  cmd_sel, alu_sel;
    logic [31:0] cmd_a, cmd_b, alu_a, alu_b, alu_out;
    logic        alu_carry;
    logic        rsp_valid, rsp_ready, rsp_carry, rsp_zero, rsp_err;
    logic [31:0] rsp_data;
    logic [32:0] sum33;

    int checks   = 0;
    int failures = 0;
    int lat;
    logic seen;

    always #5 clk = ~clk;

    alu_cmd_driver #(
        .WIDTH              (32),
        .SETTLE_CYCLES      (2),
        .LONG_SETTLE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_sel   (cmd_sel),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_acc   (cmd_acc),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_carry (alu_carry),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .rsp_zero  (rsp_zero),
        .rsp_err   (rsp_err)
    );

    // Reference ALU: carry is always the carry-out of A+B.
    assign sum33     = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_carry = sum33[32];
    always_comb begin
        alu_out = alu_a & alu_b;
        case (alu_sel)
            4'b0000: alu_out = alu_a + alu_b;
            4'b0001: alu_out = alu_a - alu_b;
            4'b0010: alu_out = alu_a * alu_b;
            4'b0011: alu_out = (alu_b == 32'd0) ? 32'd0 : alu_a / alu_b;
            default: alu_out = alu_a & alu_b;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one command for exactly one edge (E0), then counts edges until rsp_valid.
    task automatic issue(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input logic acc, output int cycles);
        @(negedge clk);
        cmd_sel   = sel;
        cmd_a     = a;
        cmd_b     = b;
        cmd_acc   = acc;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (rsp_valid) break;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_sel   = 4'd0;
        cmd_a     = 32'd0;
        cmd_b     = 32'd0;
        cmd_acc   = 1'b0;
        rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_sel", {28'd0, alu_sel}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_zero", {31'd0, rsp_zero}, 32'd1);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

        // ADD wraps to zero with carry
        issue(4'b0000, 32'hFFFF_FFFF, 32'h1, 1'b0, lat);
        chk("add_latency", lat, 32'd2);
        chk("add_data", rsp_data, 32'h0);
        chk("add_carry", {31'd0, rsp_carry}, 32'd1);
        chk("add_zero", {31'd0, rsp_zero}, 32'd1);
        chk("add_err", {31'd0, rsp_err}, 32'd0);
        consume();
        @(negedge clk);
        chk("add_done_valid", {31'd0, rsp_valid}, 32'd0);
        chk("add_done_ready", {31'd0, cmd_ready}, 32'd1);

        // Divide by zero
        issue(4'b0011, 32'd100, 32'd0, 1'b0, lat);
        chk("div0_latency", lat, 32'd1);
        chk("div0_data", rsp_data, 32'hFFFF_FFFF);
        chk("div0_err", {31'd0, rsp_err}, 32'd1);
        chk("div0_zero", {31'd0, rsp_zero}, 32'd0);
        chk("div0_carry", {31'd0, rsp_carry}, 32'd0);
        chk("div0_alu_sel", {28'd0, alu_sel}, 32'd3);
        consume();

        // DIV with long settle
        issue(4'b0011, 32'd100, 32'd7, 1'b0, lat);
        chk("div_latency", lat, 32'd4);
        chk("div_data", rsp_data, 32'd14);
        chk("div_err", {31'd0, rsp_err}, 32'd0);
        consume();

        // SUB under backpressure with ignored command pulses
        issue(4'b0001, 32'd5, 32'd3, 1'b0, lat);
        chk("sub_latency", lat, 32'd2);
        for (int i = 0; i < 5; i++) begin
            cmd_sel   = 4'b0000;
            cmd_a     = 32'd9;
            cmd_b     = 32'd9;
            cmd_valid = (i % 2) == 0;
            @(negedge clk);
            chk("bp_data", rsp_data, 32'd2);
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        cmd_valid = 1'b0;
        chk("bp_alu_a_held", alu_a, 32'd5);
        consume();
        @(negedge clk);
        chk("bp_idle_ready", {31'd0, cmd_ready}, 32'd1);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        chk("bp_no_extra_rsp", {31'd0, seen}, 32'd0);

        // Accumulator chaining
        issue(4'b0000, 32'd5, 32'd3, 1'b0, lat);
        chk("acc_first", rsp_data, 32'd8);
        consume();
        issue(4'b0001, 32'd10, 32'd2, 1'b1, lat);
`ifdef ALU_DRV_ACC_EN
        chk("acc_second", rsp_data, 32'd6);
`else
        chk("acc_second", rsp_data, 32'd8);
`endif
        consume();

        // Reset during MUL settle
        issue(4'b0010, 32'd6, 32'd7, 1'b0, lat);
        consume();
        @(negedge clk);
        cmd_sel   = 4'b0010;
        cmd_a     = 32'd6;
        cmd_b     = 32'd7;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, cmd_ready}, 32'd0);
        chk("midrst_alu_a", alu_a, 32'd0);
        chk("midrst_alu_sel", {28'd0, alu_sel}, 32'd0);
        chk("midrst_rsp_data", rsp_data, 32'd0);
        chk("midrst_rsp_zero", {31'd0, rsp_zero}, 32'd1);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_release_ready", {31'd0, cmd_ready}, 32'd1);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        chk("midrst_no_rsp", {31'd0, seen}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
